// File: rtl/fir_coeff_loader_pkg.sv
// fir_coeff_loader_pkg
//   Shared definitions for the FIR coefficient loader and its bank:
//   loader state encoding, unity-reset coefficient, the clog2 helper and
//   the packed-bus convention (tap i at bits [width*i +: width]) so the
//   writer and the FIR filter reader agree on layout.
package fir_coeff_loader_pkg;

  typedef enum logic [1:0] {
    FIR_LD_IDLE      = 2'd0,
    FIR_LD_LOAD      = 2'd1,
    FIR_LD_WAIT_SWAP = 2'd2
  } fir_ld_state_t;

  // Value of tap 0 after reset; all other taps reset to zero (pass-through).
  localparam int unsigned FIR_UNITY_COEFF = 1;

  function automatic int unsigned fir_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Low bit of tap 'tap' on the packed coefficient bus.
  function automatic int unsigned fir_tap_lsb(input int unsigned tap, input int unsigned width);
    return tap * width;
  endfunction

endpackage

// File: rtl/fir_coeff_loader_bank.sv
// fir_coeff_bank
//   Shadow/active coefficient storage. The shadow bank is written one tap
//   at a time; on 'swap' the whole shadow bank is copied in parallel into
//   the active bank, which drives packed_coeff directly from registers.
//   Optional readback port when FIR_COEFF_READBACK_EN is defined.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   wr_en          write wr_data into shadow[wr_addr]
//   wr_addr        shadow tap index
//   wr_data        coefficient, stored bit-exact
//   swap           copy shadow -> active on this edge
//   rd_addr        (FIR_COEFF_READBACK_EN) shadow read address
//   rd_data        (FIR_COEFF_READBACK_EN) shadow[rd_addr], 1-cycle latency
//   packed_coeff   active bank, tap i at [COEFF_WIDTH*i +: COEFF_WIDTH]
module fir_coeff_bank
  import fir_coeff_loader_pkg::*;
#(
  parameter  int unsigned COEFF_WIDTH = 8,
  parameter  int unsigned NUM_TAPS    = 4,
  localparam int unsigned IDX_W       = fir_clog2(NUM_TAPS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_addr,
  input  logic [COEFF_WIDTH-1:0]          wr_data,
  input  logic                            swap,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [IDX_W-1:0]                rd_addr,
  output logic [COEFF_WIDTH-1:0]          rd_data,
`endif
  output logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeff
);

  typedef logic [COEFF_WIDTH*NUM_TAPS-1:0] bank_t;
  localparam bank_t UNITY_BANK = bank_t'(FIR_UNITY_COEFF);

  logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        shadow[i[IDX_W-1:0]] <= '0;
      end
    end else if (wr_en) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packed_coeff <= UNITY_BANK;
    end else if (swap) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        packed_coeff[fir_tap_lsb(i, COEFF_WIDTH) +: COEFF_WIDTH] <= shadow[i[IDX_W-1:0]];
      end
    end
  end

`ifdef FIR_COEFF_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (int unsigned'(rd_addr) < NUM_TAPS) begin
      rd_data <= shadow[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end
`endif

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Writer side of the FIR packed coefficient bus. Accepts a framed stream
//   of coefficients (valid/ready) into a shadow bank, then on a
//   sample-aligned swap_en strobe moves the full set to the active bank.
//   Optional shadow readback port: define FIR_COEFF_READBACK_EN.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load_start     pulse: begin/restart a frame
//   load_abort     pulse: discard frame in progress (highest priority)
//   coeff_in       coefficient for tap_index
//   coeff_valid    coeff_in valid
//   coeff_ready    transfer accepted this cycle (combinational in pulses)
//   swap_en        sample-boundary strobe enabling the bank swap
//   tap_index      next tap to be written
//   busy           FSM not idle
//   load_done      pulse in the cycle the new set appears on packed_coeff
//   packed_coeff   active bank, tap i at [COEFF_WIDTH*i +: COEFF_WIDTH]
//   rd_addr        (FIR_COEFF_READBACK_EN) shadow read address
//   rd_data        (FIR_COEFF_READBACK_EN) shadow readback, 1-cycle latency
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter  int unsigned COEFF_WIDTH = 8,
  parameter  int unsigned NUM_TAPS    = 4,
  localparam int unsigned IDX_W       = fir_clog2(NUM_TAPS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_start,
  input  logic                            load_abort,
  input  logic [COEFF_WIDTH-1:0]          coeff_in,
  input  logic                            coeff_valid,
  output logic                            coeff_ready,
  input  logic                            swap_en,
  output logic [IDX_W-1:0]                tap_index,
  output logic                            busy,
  output logic                            load_done,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [IDX_W-1:0]                rd_addr,
  output logic [COEFF_WIDTH-1:0]          rd_data,
`endif
  output logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeff
);

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

  fir_ld_state_t state;
  logic          wr_en;
  logic          swap;

  // Either pulse pre-empts data/swap in the same cycle.
  always_comb begin
    coeff_ready = (state == FIR_LD_LOAD) && !load_start && !load_abort;
    wr_en       = coeff_valid && coeff_ready;
    swap        = (state == FIR_LD_WAIT_SWAP) && swap_en && !load_start && !load_abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FIR_LD_IDLE;
      tap_index <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_abort) begin
        state     <= FIR_LD_IDLE;
        tap_index <= '0;
        busy      <= 1'b0;
      end else if (load_start) begin
        state     <= FIR_LD_LOAD;
        tap_index <= '0;
        busy      <= 1'b1;
      end else begin
        case (state)
          FIR_LD_LOAD: begin
            if (wr_en) begin
              if (tap_index == LAST_TAP) begin
                state     <= FIR_LD_WAIT_SWAP;
                tap_index <= '0;
              end else begin
                tap_index <= tap_index + IDX_W'(1);
              end
            end
          end
          FIR_LD_WAIT_SWAP: begin
            if (swap) begin
              state     <= FIR_LD_IDLE;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end
          end
          default: begin
            state <= FIR_LD_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  fir_coeff_bank #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .NUM_TAPS    (NUM_TAPS)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (tap_index),
    .wr_data      (coeff_in),
    .swap         (swap),
`ifdef FIR_COEFF_READBACK_EN
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
`endif
    .packed_coeff (packed_coeff)
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           load_start = 1'b0;
  logic           load_abort = 1'b0;
  logic [W-1:0]   coeff_in = '0;
  logic           coeff_valid = 1'b0;
  logic           coeff_ready;
  logic           swap_en = 1'b0;
  logic [1:0]     tap_index;
  logic           busy;
  logic           load_done;
  logic [W*N-1:0] packed_coeff;
`ifdef FIR_COEFF_READBACK_EN
  logic [1:0]     rd_addr = '0;
  logic [W-1:0]   rd_data;
`endif

  fir_coeff_loader #(
    .COEFF_WIDTH (W),
    .NUM_TAPS    (N)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_abort   (load_abort),
    .coeff_in     (coeff_in),
    .coeff_valid  (coeff_valid),
    .coeff_ready  (coeff_ready),
    .swap_en      (swap_en),
    .tap_index    (tap_index),
    .busy         (busy),
    .load_done    (load_done),
`ifdef FIR_COEFF_READBACK_EN
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
`endif
    .packed_coeff (packed_coeff)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is "open" while coefficients are being
  // collected, "pending" once all N have arrived and a swap is awaited.
  logic [W-1:0]   m_shadow [N];
  bit             m_open;
  bit             m_pending;
  int             m_got;
  logic [W*N-1:0] exp_q [$];
  logic [W*N-1:0] last_packed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W*N-1:0] model_bank();
    logic [W*N-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = m_shadow[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_shadow[i] = '0;
    m_open    = 0;
    m_pending = 0;
    m_got     = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, check handshake outputs, advance the model.
  task automatic step(input bit st, input bit ab, input bit v, input logic [W-1:0] d, input bit sw);
    load_start  = st;
    load_abort  = ab;
    coeff_valid = v;
    coeff_in    = d;
    swap_en     = sw;
    @(negedge clk);
    check("coeff_ready", 64'(coeff_ready), 64'(m_open && !st && !ab));
    check("busy", 64'(busy), 64'(m_open || m_pending));
    check("tap_index", 64'(tap_index), 64'(m_got));
    @(posedge clk);
    if (ab) begin
      m_open = 0; m_pending = 0; m_got = 0;
    end else if (st) begin
      m_open = 1; m_pending = 0; m_got = 0;
    end else if (m_open && v) begin
      m_shadow[m_got] = d;
      m_got++;
      if (m_got == N) begin
        m_open = 0; m_pending = 1; m_got = 0;
      end
    end else if (m_pending && sw) begin
      m_pending = 0;
      exp_q.push_back(model_bank());
    end
    #1;
    load_start  = 0;
    load_abort  = 0;
    coeff_valid = 0;
    swap_en     = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  // Monitor: every load_done must match a queued swap; otherwise the
  // active bank must hold its previous value.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_packed = packed_coeff;
    end else begin
      if (load_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL load_done: unexpected pulse, packed %0h required no swap", packed_coeff);
        end else begin
          check("swap_result", 64'(packed_coeff), 64'(exp_q.pop_front()));
        end
      end else begin
        check("packed_hold", 64'(packed_coeff), 64'(last_packed));
      end
      last_packed = packed_coeff;
    end
  end

  initial begin
    model_reset();
    #2 rst_n = 0;
    @(negedge clk);
    check("rst_packed", 64'(packed_coeff), 64'h0000_0001);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(coeff_ready), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_tap", 64'(tap_index), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
    idle(2);
    check("idle_packed", 64'(packed_coeff), 64'h0000_0001);

    // Back-to-back frame then swap.
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 0, 1, 8'h33, 0);
    step(0, 0, 1, 8'h44, 0);
    step(0, 0, 0, '0, 1);
    check("frame_a", 64'(packed_coeff), 64'h4433_2211);
    idle(2);

`ifdef FIR_COEFF_READBACK_EN
    rd_addr = 2'd2;
    @(posedge clk);
    #1;
    check("readback", 64'(rd_data), 64'h33);
`endif

    // Valid every other cycle, swap withheld for 10 cycles.
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, k % 2 == 1, 8'(8'hA0 + k), 0);
    idle(10);
    check("held_old", 64'(packed_coeff), 64'h4433_2211);
    step(0, 0, 0, '0, 1);
    check("frame_b", 64'(packed_coeff), 64'hA7A5_A3A1);

    // Restart after two coefficients.
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 8'h55, 0);
    step(0, 0, 1, 8'h66, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 8'h01, 0);
    step(0, 0, 1, 8'h02, 0);
    step(0, 0, 1, 8'h03, 0);
    step(0, 0, 1, 8'hFF, 0);
    step(0, 0, 0, '0, 1);
    check("frame_restart", 64'(packed_coeff), 64'hFF03_0201);

    // Abort coincident with swap in WAIT_SWAP.
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < N; k++) step(0, 0, 1, 8'(8'h70 + k), 0);
    step(0, 1, 0, '0, 1);
    idle(2);
    check("abort_swap", 64'(packed_coeff), 64'hFF03_0201);

    // Restart coincident with swap in WAIT_SWAP.
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < N; k++) step(0, 0, 1, 8'(8'h80 + k), 0);
    step(1, 0, 0, '0, 1);
    idle(2);
    check("start_swap", 64'(packed_coeff), 64'hFF03_0201);
    step(0, 1, 0, '0, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0,
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0);
    end

    // Reset mid-frame restores the unity active bank.
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, 8'h12, 0);
    #2 rst_n = 0;
    #1;
    check("midrst_packed", 64'(packed_coeff), 64'h0000_0001);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_tap", 64'(tap_index), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    idle(2);
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < N; k++) step(0, 0, 1, 8'(8'hC0 + k), 0);
    step(0, 0, 0, '0, 1);
    check("post_rst", 64'(packed_coeff), 64'hC3C2_C1C0);
    idle(2);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
